// File: rtl/nn_act_pkg.sv
// Shared constants and helpers for the activation-function blocks.
package nn_act_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 4;
  localparam int unsigned FW   = 4;
  localparam int unsigned IDW  = 2;
  // Width of the interpolation sum before saturation.
  localparam int unsigned SW   = DW + FW + 2;

  // Clamp a wide signed value into the DW-bit signed range.
  function automatic logic [DW-1:0] sat_signed(input logic signed [SW-1:0] v);
    logic [DW-1:0] r;
    // In range when all bits from the DW-bit sign position upward agree.
    if ((&v[SW-1:DW-1]) || !(|v[SW-1:DW-1])) begin
      r = v[DW-1:0];
    end else if (v[SW-1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around;
// the pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  gidx_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;

  // First requester at or after the pointer wins; grant is masked by en_i.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found   = 1'b0;
    gidx_o  = '0;
    grant_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        gidx_o = IDW'(idx);
      end
    end
    if (en_i && found) begin
      grant_o[gidx_o] = 1'b1;
    end
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = IDW'((32'(gidx_o) + 1) % NREQ);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sigmoid_lut_scheduler.sv
// Shares one sigmoid LUT among NREQ requesters: round-robin grant, stage A
// holds the operand and drives the LUT address, stage B interpolates and
// holds the result until the consumer takes it.
module sigmoid_lut_scheduler
  import nn_act_pkg::*;
#(
  parameter int unsigned NREQ = nn_act_pkg::NREQ,
  parameter int unsigned DW   = nn_act_pkg::DW,
  parameter int unsigned AW   = nn_act_pkg::AW,
  parameter int unsigned FW   = nn_act_pkg::FW,
  parameter int unsigned IDW  = nn_act_pkg::IDW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      lut_address,
  input  logic [DW-1:0]      lut_base,
  input  logic [DW-1:0]      lut_next_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_y,
  output logic               idle
);

  localparam int unsigned PW = DW + FW + 2;

  logic            va_q, va_d;
  logic [IDW-1:0]  ida_q, ida_d;
  logic [AW-1:0]   addra_q, addra_d;
  logic [FW-1:0]   fraca_q, fraca_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_y_q, rsp_y_d;

  logic            adv_a, adv_b, hs;
  logic [IDW-1:0]  gidx;
  logic [DW-1:0]   x_sel;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] diff_ext, frac_ext, base_ext, prod, sum;
  logic [DW-1:0]        y_sat;

  assign adv_b = !rsp_valid_q || rsp_ready;
  assign adv_a = !va_q || adv_b;
  assign hs    = |req_ready;
  assign x_sel = req_x[gidx*DW +: DW];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req_valid),
    .en_i    (adv_a),
    .grant_o (req_ready),
    .gidx_o  (gidx)
  );

  // Linear interpolation between base and next, floored, then saturated.
  always_comb begin
    diff     = $signed({lut_next_data[DW-1], lut_next_data}) - $signed({lut_base[DW-1], lut_base});
    diff_ext = {{(PW-DW-1){diff[DW]}}, diff};
    frac_ext = $signed({{(PW-FW){1'b0}}, fraca_q});
    base_ext = $signed({{(PW-DW){lut_base[DW-1]}}, lut_base});
    prod     = diff_ext * frac_ext;
    sum      = base_ext + (prod >>> FW);
    y_sat    = sat_signed(sum);
  end

  // Stage A next state: load on handshake, empty when advancing without one.
  always_comb begin
    va_d    = va_q;
    ida_d   = ida_q;
    addra_d = addra_q;
    fraca_d = fraca_q;
    if (adv_a) begin
      va_d = hs;
      if (hs) begin
        ida_d   = gidx;
        addra_d = x_sel[DW-1:FW];
        fraca_d = x_sel[FW-1:0];
      end
    end
  end

  // Stage B next state: result only overwritten when the slot frees up.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    if (adv_b) begin
      rsp_valid_d = va_q;
      if (va_q) begin
        rsp_id_d = ida_q;
        rsp_y_d  = y_sat;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      va_q        <= 1'b0;
      ida_q       <= '0;
      addra_q     <= '0;
      fraca_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      va_q        <= va_d;
      ida_q       <= ida_d;
      addra_q     <= addra_d;
      fraca_q     <= fraca_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign lut_address = addra_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_y       = rsp_y_q;
  assign idle        = !va_q && !rsp_valid_q;

endmodule

// File: tb/tb_sigmoid_lut_scheduler.sv
// Scoreboard bench for sigmoid_lut_scheduler with a behavioural sigmoid LUT.
module tb_sigmoid_lut_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        lut_address;
  logic [DW-1:0]     lut_base;
  logic [DW-1:0]     lut_next_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_y;
  logic              idle;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] y;
  } exp_t;

  logic [7:0] lut_tbl [16] = '{8'd8, 8'd11, 8'd14, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15,
                               8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd4};

  exp_t       sb[$];
  int         grants[$];
  int         pop_cyc[$];
  logic [7:0] pend [NREQ][$];
  int         acc_cnt [NREQ];
  int         cyc = 0;
  int         delivered = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  sigmoid_lut_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_ready     (req_ready),
    .lut_address   (lut_address),
    .lut_base      (lut_base),
    .lut_next_data (lut_next_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_y         (rsp_y),
    .idle          (idle)
  );

  // Behavioural LUT: clamps at segment 7, wraps 15 -> 0.
  assign lut_base      = lut_tbl[lut_address];
  assign lut_next_data = (lut_address == 4'd7) ? lut_tbl[7] : lut_tbl[lut_address + 4'd1];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_y(input logic [7:0] x);
    int a, f, b, n, y;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = int'($signed(lut_tbl[a]));
    n = (a == 7) ? b : int'($signed(lut_tbl[(a + 1) % 16]));
    y = b + (((n - b) * f) >>> 4);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || !idle;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_cnt[i] < pend[i].size()) b = 1'b1;
    end
    return b;
  endfunction

  // Monitor: pushes expectations on accepted operands, checks delivered results.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      check_eq("ready_onehot0", int'($onehot0(req_ready)), 1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_id", int'(rsp_id), int'(e.id));
          check_eq("rsp_y", int'($signed(rsp_y)), int'($signed(e.y)));
        end
        delivered++;
        pop_cyc.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back({2'(i), model_y(req_x[i*DW +: DW])});
          grants.push_back(i);
          acc_cnt[i]++;
        end
      end
    end
  end

  // Requester driver: present the oldest unaccepted operand of each queue.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_cnt[i] < pend[i].size()) begin
        req_valid[i]         = 1'b1;
        req_x[i*DW +: DW]    = pend[i][acc_cnt[i]];
      end else begin
        req_valid[i]         = 1'b0;
        req_x[i*DW +: DW]    = '0;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy()) check_eq("drain_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int g0, p0, d0, k;
    int exp_g [6];
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_x     = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_rsp_valid", int'(rsp_valid), 0);
    check_eq("reset_rsp_id", int'(rsp_id), 0);
    check_eq("reset_rsp_y", int'(rsp_y), 0);
    check_eq("reset_lut_address", int'(lut_address), 0);
    check_eq("reset_req_ready", int'(req_ready), 0);
    check_eq("reset_idle", int'(idle), 1);
    rst = 1'b0;

    // Single operand on requester 0, latency check.
    @(negedge clk);
    pend[0].push_back(8'h08);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(req_valid[0] && req_ready[0]) && k < 10);
    check_eq("t1_accept_seen", int'(req_valid[0] && req_ready[0]), 1);
    @(negedge clk);
    check_eq("t1_lut_address", int'(lut_address), 0);
    check_eq("t1_lut_base", int'(lut_base), 8);
    check_eq("t1_lut_next", int'(lut_next_data), 11);
    check_eq("t1_rsp_valid_early", int'(rsp_valid), 0);
    @(negedge clk);
    check_eq("t1_rsp_valid", int'(rsp_valid), 1);
    check_eq("t1_rsp_id", int'(rsp_id), 0);
    check_eq("t1_rsp_y", int'(rsp_y), 9);
    wait_drain(50);

    // Segment boundaries: clamp at 7, wrap 15->0, negative segments.
    pend[0].push_back(8'h7F);
    pend[0].push_back(8'hF8);
    pend[0].push_back(8'h88);
    pend[0].push_back(8'hE8);
    pend[0].push_back(8'hD0);
    wait_drain(100);

    // All four at once from a reset pointer: grants 0,1,2,3 back to back.
    pulse_reset();
    g0 = grants.size();
    p0 = pop_cyc.size();
    pend[0].push_back(8'h10);
    pend[1].push_back(8'h34);
    pend[2].push_back(8'hA0);
    pend[3].push_back(8'hF4);
    wait_drain(100);
    check_eq("t3_grant_count", grants.size() - g0, 4);
    check_eq("t3_pop_count", pop_cyc.size() - p0, 4);
    if (grants.size() - g0 >= 4) begin
      for (int i = 0; i < 4; i++) check_eq("t3_grant_order", grants[g0 + i], i);
    end
    if (pop_cyc.size() - p0 >= 4) begin
      check_eq("t3_rsp_span", pop_cyc[p0 + 3] - pop_cyc[p0], 3);
    end

    // Requester 1 held, requester 3 competing: alternation 1,3,1,3 then 1,1.
    g0 = grants.size();
    for (int i = 0; i < 4; i++) pend[1].push_back(8'(8'h12 + 8'(i * 16)));
    pend[3].push_back(8'h9C);
    pend[3].push_back(8'hFF);
    wait_drain(100);
    exp_g = '{1, 3, 1, 3, 1, 1};
    check_eq("t4_grant_count", grants.size() - g0, 6);
    if (grants.size() - g0 >= 6) begin
      for (int i = 0; i < 6; i++) check_eq("t4_grant_order", grants[g0 + i], exp_g[i]);
    end

    // Backpressure with three pending operands.
    d0 = delivered;
    @(negedge clk);
    rsp_ready = 1'b0;
    pend[0].push_back(8'h2A);
    pend[1].push_back(8'hC7);
    pend[2].push_back(8'h05);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("t5_req_ready_blocked", int'(req_ready), 0);
      check_eq("t5_rsp_valid_held", int'(rsp_valid), 1);
      if (sb.size() > 0) begin
        check_eq("t5_rsp_id_stable", int'(rsp_id), int'(sb[0].id));
        check_eq("t5_rsp_y_stable", int'($signed(rsp_y)), int'($signed(sb[0].y)));
      end else begin
        check_eq("t5_sb_nonempty", 0, 1);
      end
    end
    rsp_ready = 1'b1;
    wait_drain(100);
    check_eq("t5_delivered", delivered - d0, 3);

    // Reset with two operands in flight: nothing comes out afterwards.
    @(negedge clk);
    rsp_ready = 1'b0;
    pend[0].push_back(8'h44);
    pend[1].push_back(8'hB3);
    repeat (3) @(negedge clk);
    check_eq("t6_busy_before_rst", int'(idle), 0);
    d0 = delivered;
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rsp_valid", int'(rsp_valid), 0);
    check_eq("t6_rsp_id", int'(rsp_id), 0);
    check_eq("t6_rsp_y", int'(rsp_y), 0);
    check_eq("t6_lut_address", int'(lut_address), 0);
    check_eq("t6_req_ready", int'(req_ready), 0);
    check_eq("t6_idle", int'(idle), 1);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("t6_no_stray_rsp", int'(rsp_valid), 0);
    end
    check_eq("t6_delivered", delivered - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait above misbehaves.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d, want %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
